// File: rtl/pipe_step_ctrl.sv
// pipe_step_ctrl: pipeline advance strobe generator (step / free-run / PC breakpoint) with advance and stall counters.
// Optional macro RUN_LIMIT_EN adds run_limit/limit_hit to stop free-run after a programmed advance count.
module pipe_step_ctrl #(
  parameter int RATE_DIV = 2500000,
  parameter int PC_W     = 32,
  parameter int CNT_W    = 16
) (
  input  logic             CCLK,
  input  logic             RSTN,
  input  logic             step_btn,
  input  logic             run_sw,
  input  logic             brk_en,
  input  logic [PC_W-1:0]  brk_pc,
  input  logic [PC_W-1:0]  pc,
  input  logic             dstall,
  input  logic             cstall,
`ifdef RUN_LIMIT_EN
  input  logic [CNT_W-1:0] run_limit,
  output logic             limit_hit,
`endif
  output logic             adv,
  output logic             running,
  output logic             brk_hit,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int DW = 24;
  typedef enum logic [1:0] {IDLE, RUN, BRK} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, stall_q, stall_d;
  logic step_q, adv_q, adv_d, skip_q, skip_d;
  logic step_rise, tc, pc_brk;
`ifdef RUN_LIMIT_EN
  logic lim_q, lim_d, lim_trip;
  assign lim_trip = (run_limit != '0) && (cyc_q == run_limit - CNT_W'(1));
  assign limit_hit = lim_q;
`endif
  assign step_rise = step_btn & ~step_q;
  assign tc = div_q == DW'(RATE_DIV - 1);
  assign pc_brk = brk_en && (pc == brk_pc) && !skip_q;
  assign adv = adv_q;
  assign running = state_q == RUN;
  assign brk_hit = state_q == BRK;
  assign cyc_cnt = cyc_q;
  assign stall_cnt = stall_q;
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    adv_d = 1'b0;
    skip_d = skip_q;
`ifdef RUN_LIMIT_EN
    lim_d = lim_q;
`endif
    // counters see the strobe one cycle late, so dstall/cstall are sampled while adv is high
    cyc_d = (adv_q && !(&cyc_q)) ? cyc_q + CNT_W'(1) : cyc_q;
    stall_d = (adv_q && (dstall | cstall) && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
    unique case (state_q)
      IDLE: begin
        if (run_sw) begin
          state_d = RUN;
          div_d = '0;
        end else adv_d = step_rise;
      end
      RUN: begin
        if (!run_sw) begin
          state_d = IDLE;
          div_d = '0;
        end else if (tc) begin
          div_d = '0;
          if (pc_brk) state_d = BRK;
          else begin
            adv_d = 1'b1;
            skip_d = 1'b0;
`ifdef RUN_LIMIT_EN
            if (lim_trip) begin
              state_d = BRK;
              lim_d = 1'b1;
            end
`endif
          end
        end else div_d = div_q + DW'(1);
      end
      BRK: begin
        div_d = '0;
        if (!run_sw) begin
          state_d = IDLE;
`ifdef RUN_LIMIT_EN
          lim_d = 1'b0;
`endif
        end else if (step_rise) begin
          state_d = RUN;
          adv_d = 1'b1;
          skip_d = 1'b1;
`ifdef RUN_LIMIT_EN
          lim_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      div_q <= '0;
      step_q <= 1'b1;
      adv_q <= 1'b0;
      skip_q <= 1'b0;
      cyc_q <= '0;
      stall_q <= '0;
`ifdef RUN_LIMIT_EN
      lim_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      step_q <= step_btn;
      adv_q <= adv_d;
      skip_q <= skip_d;
      cyc_q <= cyc_d;
      stall_q <= stall_d;
`ifdef RUN_LIMIT_EN
      lim_q <= lim_d;
`endif
    end
  end
endmodule

// File: tb/tb_pipe_step_ctrl.sv
// tb_pipe_step_ctrl: directed table-driven bench for pipe_step_ctrl (RATE_DIV=4), plus a CNT_W=2 copy for saturation.
module tb_pipe_step_ctrl;
  logic CCLK, RSTN, step_btn, run_sw, brk_en, dstall, cstall, pc_clr;
  logic [31:0] brk_pc, pc;
  logic [29:0] pc_n;
  logic adv, running, brk_hit, adv2, running2, brk_hit2;
  logic [15:0] cyc_cnt, stall_cnt;
  logic [1:0] cyc_cnt2, stall_cnt2;
`ifdef RUN_LIMIT_EN
  logic [15:0] run_limit;
  logic limit_hit, limit_hit2;
`endif
  int checks, errors, adv_seen, wide_err, base;
  logic adv_prev;

  typedef struct packed {
    logic stp, run, ds, cs, e_adv, e_run;
    logic [15:0] e_cyc, e_stall;
  } vec_t;
  vec_t vecs[12];

  pipe_step_ctrl #(.RATE_DIV(4), .PC_W(32), .CNT_W(16)) dut (
    .CCLK(CCLK), .RSTN(RSTN), .step_btn(step_btn), .run_sw(run_sw), .brk_en(brk_en),
    .brk_pc(brk_pc), .pc(pc), .dstall(dstall), .cstall(cstall),
`ifdef RUN_LIMIT_EN
    .run_limit(run_limit), .limit_hit(limit_hit),
`endif
    .adv(adv), .running(running), .brk_hit(brk_hit), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt)
  );

  pipe_step_ctrl #(.RATE_DIV(4), .PC_W(32), .CNT_W(2)) dut2 (
    .CCLK(CCLK), .RSTN(RSTN), .step_btn(step_btn), .run_sw(run_sw), .brk_en(brk_en),
    .brk_pc(brk_pc), .pc(pc), .dstall(dstall), .cstall(cstall),
`ifdef RUN_LIMIT_EN
    .run_limit(run_limit[1:0]), .limit_hit(limit_hit2),
`endif
    .adv(adv2), .running(running2), .brk_hit(brk_hit2), .cyc_cnt(cyc_cnt2), .stall_cnt(stall_cnt2)
  );

  initial CCLK = 1'b0;
  always #5 CCLK = ~CCLK;

  // pipeline PC model: advances by 4 on every adv strobe
  always @(posedge CCLK) pc_n <= pc_clr ? '0 : pc_n + {29'd0, adv};
  assign pc = {pc_n, 2'b00};

  initial begin
    adv_seen = 0;
    wide_err = 0;
    adv_prev = 1'b0;
  end
  always @(negedge CCLK) begin
    if (adv) adv_seen++;
    if (adv && adv_prev) wide_err++;
    adv_prev = adv;
  end

  task automatic tick();
    @(posedge CCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
    tick();
  endtask

  task automatic step(input logic ds);
    step_btn = 1'b1;
    tick();
    dstall = ds;
    step_btn = 1'b0;
    tick();
    dstall = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RSTN = 1'b0;
    step_btn = 1'b0;
    run_sw = 1'b0;
    brk_en = 1'b0;
    brk_pc = 32'h0;
    dstall = 1'b0;
    cstall = 1'b0;
    pc_clr = 1'b1;
`ifdef RUN_LIMIT_EN
    run_limit = 16'd0;
`endif
    //            stp   run   ds    cs    adv   run   cyc    stall
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 16'd1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 16'd1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2, 16'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 16'd1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 16'd1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 16'd1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 16'd1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 16'd1};

    tick();
    tick();
    chk("rst_adv", adv, 0);
    chk("rst_running", running, 0);
    chk("rst_brk_hit", brk_hit, 0);
    chk("rst_cyc", cyc_cnt, 0);
    chk("rst_stall", stall_cnt, 0);
    RSTN = 1'b1;
    pc_clr = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step_btn = vecs[i].stp;
      run_sw = vecs[i].run;
      dstall = vecs[i].ds;
      cstall = vecs[i].cs;
      tick();
      chk($sformatf("vec%0d_adv", i), adv, vecs[i].e_adv);
      chk($sformatf("vec%0d_running", i), running, vecs[i].e_run);
      chk($sformatf("vec%0d_cyc", i), cyc_cnt, vecs[i].e_cyc);
      chk($sformatf("vec%0d_stall", i), stall_cnt, vecs[i].e_stall);
    end
    dstall = 1'b0;
    cstall = 1'b0;

    // button held through reset must not step
    step_btn = 1'b1;
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
    base = adv_seen;
    repeat (10) tick();
    chk("held_btn_adv", adv_seen - base, 0);
    chk("held_btn_cyc", cyc_cnt, 0);
    step_btn = 1'b0;

    // free-run: one advance every 4 cycles
    do_reset();
    base = adv_seen;
    run_sw = 1'b1;
    repeat (21) tick();
    chk("run_running", running, 1);
    run_sw = 1'b0;
    repeat (10) tick();
    chk("run_adv_count", adv_seen - base, 5);
    chk("run_cyc", cyc_cnt, 5);
    chk("run_exit_running", running, 0);

    // breakpoint at 0xC, then step past it
    do_reset();
    pc_clr = 1'b1;
    tick();
    pc_clr = 1'b0;
    brk_en = 1'b1;
    brk_pc = 32'h0000000C;
    base = adv_seen;
    run_sw = 1'b1;
    repeat (18) tick();
    chk("brk_hit", brk_hit, 1);
    chk("brk_running", running, 0);
    chk("brk_adv_count", adv_seen - base, 3);
    chk("brk_pc_model", pc, 32'hC);
    repeat (8) tick();
    chk("brk_hold_adv", adv_seen - base, 3);
    step_btn = 1'b1;
    tick();
    chk("brk_step_adv", adv, 1);
    chk("brk_step_hit", brk_hit, 0);
    chk("brk_step_running", running, 1);
    step_btn = 1'b0;
    repeat (6) tick();
    chk("brk_resume_count", adv_seen - base, 5);
    chk("brk_resume_hit", brk_hit, 0);
    run_sw = 1'b0;
    brk_en = 1'b0;
    tick();

    // six steps, two stalled; narrow copy saturates
    do_reset();
    step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    chk("stall_cyc", cyc_cnt, 6);
    chk("stall_stall", stall_cnt, 2);
    chk("sat_cyc2", cyc_cnt2, 3);
    chk("sat_stall2", stall_cnt2, 2);
    step(1'b1);
    step(1'b1);
    chk("sat_cyc2_hold", cyc_cnt2, 3);
    chk("sat_stall2_hold", stall_cnt2, 3);
    step(1'b1);
    chk("sat_stall2_hold2", stall_cnt2, 3);

    // reset in the middle of RUN
    run_sw = 1'b1;
    repeat (6) tick();
    RSTN = 1'b0;
    #1;
    chk("midrst_running", running, 0);
    chk("midrst_cyc", cyc_cnt, 0);
    chk("midrst_adv", adv, 0);
    tick();
    base = adv_seen;
    RSTN = 1'b1;
    tick();
    chk("midrst_release_adv", adv, 0);
    chk("midrst_release_running", running, 1);
    chk("midrst_release_count", adv_seen - base, 0);
    run_sw = 1'b0;
    tick();

`ifdef RUN_LIMIT_EN
    do_reset();
    run_limit = 16'd3;
    base = adv_seen;
    run_sw = 1'b1;
    repeat (30) tick();
    chk("lim_adv_count", adv_seen - base, 3);
    chk("lim_limit_hit", limit_hit, 1);
    chk("lim_brk_hit", brk_hit, 1);
    chk("lim_cyc", cyc_cnt, 3);
    run_sw = 1'b0;
    tick();
    chk("lim_clear", limit_hit, 0);
    chk("lim_brk_clear", brk_hit, 0);
    run_limit = 16'd0;
`endif

    chk("adv_width", wide_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
